// File: rtl/draw_sequencer.sv
// Frame sequencer for the VGA draw path: erase pass over all enabled channels,
// one game-logic update pulse plus a settle wait, then a colour pass. Each
// channel owns the plot port for its LOAD+DRAW slot.
module draw_sequencer #(
  parameter int NCH = 3,
  parameter int XW  = 10,
  parameter int YW  = 10,
  parameter int CW  = 3,
  parameter int LW  = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_tick,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*LW-1:0] ch_len,
  input  logic [LW-1:0]     upd_len,
  input  logic [CW-1:0]     bg_colour,
  input  logic [NCH*XW-1:0] ch_x,
  input  logic [NCH*YW-1:0] ch_y,
  input  logic [NCH*CW-1:0] ch_colour,
  input  logic [NCH-1:0]    ch_we,
  output logic [NCH-1:0]    go,
  output logic              upd_pulse,
  output logic [XW-1:0]     vga_x,
  output logic [YW-1:0]     vga_y,
  output logic [CW-1:0]     vga_colour,
  output logic              vga_we,
  output logic              pass,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, UPD, UPD_WAIT, SWAP} state_t;

  state_t                   state, state_nx;
  logic                     pending;
  logic [IW-1:0]            idx, idx_nx;
  logic [LW-1:0]            cnt;
  logic [NCH-1:0]           en_q;
  logic [NCH-1:0][LW-1:0]   len_q;
  logic [NCH-1:0][LW-1:0]   len_live;
  logic [NCH-1:0][XW-1:0]   x_a;
  logic [NCH-1:0][YW-1:0]   y_a;
  logic [NCH-1:0][CW-1:0]   col_a;
  logic [NCH-1:0]           elig_live, elig_q;
  logic                     first_live_ok, first_q_ok, next_ok;
  logic [IW-1:0]            first_live, first_q, next_i;

  assign len_live = ch_len;
  assign x_a      = ch_x;
  assign y_a      = ch_y;
  assign col_a    = ch_colour;

  // Eligibility: live view decides the start in IDLE, latched view runs the frame.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign elig_live[i] = ch_en[i] && (len_live[i] != '0);
    assign elig_q[i]    = en_q[i]  && (len_q[i]    != '0);
  end

  // Priority search: lowest live/latched eligible channel and next one above idx.
  always_comb begin
    first_live_ok = 1'b0; first_live = '0;
    first_q_ok    = 1'b0; first_q    = '0;
    next_ok       = 1'b0; next_i     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig_live[i]) begin first_live_ok = 1'b1; first_live = IW'(i); end
      if (elig_q[i])    begin first_q_ok    = 1'b1; first_q    = IW'(i); end
      if (elig_q[i] && (i > int'(idx))) begin next_ok = 1'b1; next_i = IW'(i); end
    end
  end

  // Next-state and channel index selection.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: if (frame_tick || pending) begin
        if (first_live_ok) begin state_nx = LOAD; idx_nx = first_live; end
        else state_nx = UPD;
      end
      LOAD: state_nx = DRAW;
      DRAW: if (cnt == len_q[idx] - LW'(1)) begin
        if (next_ok) begin state_nx = LOAD; idx_nx = next_i; end
        else state_nx = pass ? SWAP : UPD;
      end
      UPD:      state_nx = (upd_len == '0) ? SWAP : UPD_WAIT;
      UPD_WAIT: if (cnt == upd_len - LW'(1)) state_nx = SWAP;
      SWAP: if (!pass) begin
        // No eligible channel: the colour pass collapses to the closing SWAP.
        if (first_q_ok) begin state_nx = LOAD; idx_nx = first_q; end
        else state_nx = SWAP;
      end else state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, counter, pass, tick queue and frame-config latch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      pass    <= 1'b0;
      pending <= 1'b0;
      en_q    <= '0;
      len_q   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (state == IDLE && state_nx != IDLE) begin
        en_q  <= ch_en;
        len_q <= ch_len;
      end
      case (state)
        LOAD, UPD:      cnt <= '0;
        DRAW, UPD_WAIT: cnt <= cnt + LW'(1);
        default:        cnt <= cnt;
      endcase
      if (state == SWAP) pass <= ~pass;
      // IDLE consumes the queued tick; a tick arriving that same cycle re-queues.
      if (state == IDLE) pending <= pending & frame_tick;
      else if (frame_tick) pending <= 1'b1;
    end
  end

  // Output decode from the current state.
  always_comb begin
    go         = '0;
    upd_pulse  = 1'b0;
    frame_done = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_we     = 1'b0;
    if (state == LOAD) go[idx] = 1'b1;
    if (state == LOAD || state == DRAW) begin
      vga_x      = x_a[idx];
      vga_y      = y_a[idx];
      vga_colour = pass ? col_a[idx] : bg_colour;
      vga_we     = ch_we[idx];
    end
    if (state == UPD) upd_pulse = 1'b1;
    if (state == SWAP && pass) frame_done = 1'b1;
  end

  assign busy    = (state != IDLE);
  assign overrun = busy && frame_tick && pending;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: frame timing, pass colouring, masking,
// tick queueing, async reset and minimum lengths.
module tb_draw_sequencer;
  localparam int NCH = 3, XW = 10, YW = 10, CW = 3, LW = 20;
  localparam int MAXC = 400;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              frame_tick = 1'b0;
  logic [NCH-1:0]    ch_en = '0;
  logic [NCH*LW-1:0] ch_len = '0;
  logic [LW-1:0]     upd_len = '0;
  logic [CW-1:0]     bg_colour = '0;
  logic [NCH*XW-1:0] ch_x = '0;
  logic [NCH*YW-1:0] ch_y = '0;
  logic [NCH*CW-1:0] ch_colour = '0;
  logic [NCH-1:0]    ch_we = '0;
  logic [NCH-1:0]    go;
  logic              upd_pulse, vga_we, pass, busy, frame_done, overrun;
  logic [XW-1:0]     vga_x;
  logic [YW-1:0]     vga_y;
  logic [CW-1:0]     vga_colour;

  int checks = 0;
  int failures = 0;

  logic [NCH-1:0] go_log   [0:MAXC-1];
  logic [XW-1:0]  x_log    [0:MAXC-1];
  logic [YW-1:0]  y_log    [0:MAXC-1];
  logic [CW-1:0]  col_log  [0:MAXC-1];
  logic           upd_log  [0:MAXC-1];
  logic           fd_log   [0:MAXC-1];
  logic           busy_log [0:MAXC-1];
  logic           ovr_log  [0:MAXC-1];
  logic           we_log   [0:MAXC-1];
  logic           pass_log [0:MAXC-1];

  draw_sequencer #(.NCH(NCH), .XW(XW), .YW(YW), .CW(CW), .LW(LW)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .ch_en(ch_en),
    .ch_len(ch_len), .upd_len(upd_len), .bg_colour(bg_colour), .ch_x(ch_x),
    .ch_y(ch_y), .ch_colour(ch_colour), .ch_we(ch_we), .go(go),
    .upd_pulse(upd_pulse), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_we(vga_we), .pass(pass), .busy(busy), .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic set_cfg(input logic [NCH-1:0] en, input int l0, input int l1,
                         input int l2, input int ul);
    ch_en   = en;
    ch_len  = {LW'(l2), LW'(l1), LW'(l0)};
    upd_len = LW'(ul);
  endtask

  task automatic do_reset();
    frame_tick = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  // Tick once, then log n cycles; cycle 1 is the first cycle after IDLE accepts.
  // Extra ticks are driven during cycles t2 and t3 (0 = none).
  task automatic run_frame(input int ncyc, input int t2, input int t3);
    for (int k = 0; k < MAXC; k++) begin
      go_log[k] = '0; x_log[k] = '0; y_log[k] = '0; col_log[k] = '0;
      upd_log[k] = 0; fd_log[k] = 0; busy_log[k] = 0; ovr_log[k] = 0;
      we_log[k] = 0; pass_log[k] = 0;
    end
    frame_tick = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      frame_tick = (n == t2) || (n == t3);
      #1;
      go_log[n] = go; x_log[n] = vga_x; y_log[n] = vga_y; col_log[n] = vga_colour;
      upd_log[n] = upd_pulse; fd_log[n] = frame_done; busy_log[n] = busy;
      ovr_log[n] = overrun; we_log[n] = vga_we; pass_log[n] = pass;
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({go, upd_pulse, vga_x, vga_y, vga_colour, vga_we, pass, busy, frame_done, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs go=%b upd=%b x=%0d y=%0d col=%0d we=%b pass=%b busy=%b fd=%b ovr=%b (all required 0)",
               go, upd_pulse, vga_x, vga_y, vga_colour, vga_we, pass, busy, frame_done, overrun);
    end
  endtask

  task automatic test_full_frame();
    int nupd, nfd, ngo;
    do_reset();
    set_cfg(3'b111, 30, 32, 10, 12);
    run_frame(170, 0, 0);
    nupd = 0; nfd = 0; ngo = 0;
    for (int n = 1; n <= 170; n++) begin
      nupd += int'(upd_log[n]); nfd += int'(fd_log[n]); ngo += $countones(go_log[n]);
    end
    checks++;
    if (go_log[1] !== 3'b001 || go_log[32] !== 3'b010 || go_log[65] !== 3'b100) begin
      failures++;
      $display("FAIL erase_go go@1=%b go@32=%b go@65=%b required 001/010/100", go_log[1], go_log[32], go_log[65]);
    end
    checks++;
    if (go_log[90] !== 3'b001 || go_log[121] !== 3'b010 || go_log[154] !== 3'b100) begin
      failures++;
      $display("FAIL colour_go go@90=%b go@121=%b go@154=%b required 001/010/100", go_log[90], go_log[121], go_log[154]);
    end
    checks++;
    if (nupd !== 1 || upd_log[76] !== 1'b1) begin
      failures++;
      $display("FAIL upd_pulse count=%0d at76=%b required 1/1", nupd, upd_log[76]);
    end
    checks++;
    if (nfd !== 1 || fd_log[165] !== 1'b1 || busy_log[166] !== 1'b0) begin
      failures++;
      $display("FAIL frame_done count=%0d at165=%b busy@166=%b required 1/1/0", nfd, fd_log[165], busy_log[166]);
    end
    checks++;
    if (ngo !== 6 || pass_log[89] !== 1'b0 || pass_log[90] !== 1'b1) begin
      failures++;
      $display("FAIL go_pass gos=%0d pass@89=%b pass@90=%b required 6/0/1", ngo, pass_log[89], pass_log[90]);
    end
  endtask

  task automatic test_pass_colour();
    do_reset();
    set_cfg(3'b111, 30, 32, 10, 12);
    ch_x = {10'd300, 10'd123, 10'd7};
    ch_y = {10'd200, 10'd45, 10'd9};
    ch_colour = {3'b011, 3'b101, 3'b010};
    ch_we = 3'b111;
    bg_colour = 3'b000;
    run_frame(170, 0, 0);
    checks++;
    if (col_log[40] !== 3'b000 || x_log[40] !== 10'd123 || y_log[40] !== 10'd45 || we_log[40] !== 1'b1) begin
      failures++;
      $display("FAIL erase_plot col=%b x=%0d y=%0d we=%b required 000/123/45/1", col_log[40], x_log[40], y_log[40], we_log[40]);
    end
    checks++;
    if (col_log[130] !== 3'b101 || x_log[130] !== 10'd123 || y_log[130] !== 10'd45 || we_log[130] !== 1'b1) begin
      failures++;
      $display("FAIL colour_plot col=%b x=%0d y=%0d we=%b required 101/123/45/1", col_log[130], x_log[130], y_log[130], we_log[130]);
    end
    checks++;
    if (we_log[76] !== 1'b0 || x_log[80] !== 10'd0 || col_log[89] !== 3'b000) begin
      failures++;
      $display("FAIL idle_mux we@76=%b x@80=%0d col@89=%b required 0/0/000", we_log[76], x_log[80], col_log[89]);
    end
    checks++;
    if (x_log[10] !== 10'd7 || col_log[100] !== 3'b010 || col_log[160] !== 3'b011) begin
      failures++;
      $display("FAIL other_ch x@10=%0d col@100=%b col@160=%b required 7/010/011", x_log[10], col_log[100], col_log[160]);
    end
    ch_we = '0;
  endtask

  task automatic test_masking();
    int g1;
    do_reset();
    set_cfg(3'b101, 30, 32, 10, 12);
    run_frame(110, 0, 0);
    g1 = 0;
    for (int n = 1; n <= 110; n++) g1 += int'(go_log[n][1]);
    checks++;
    if (g1 !== 0 || go_log[32] !== 3'b100 || upd_log[43] !== 1'b1 || fd_log[99] !== 1'b1) begin
      failures++;
      $display("FAIL mask_en go1=%0d go@32=%b upd@43=%b fd@99=%b required 0/100/1/1", g1, go_log[32], upd_log[43], fd_log[99]);
    end
    do_reset();
    set_cfg(3'b111, 30, 0, 10, 12);
    run_frame(110, 0, 0);
    g1 = 0;
    for (int n = 1; n <= 110; n++) g1 += int'(go_log[n][1]);
    checks++;
    if (g1 !== 0 || go_log[32] !== 3'b100 || fd_log[99] !== 1'b1) begin
      failures++;
      $display("FAIL mask_len go1=%0d go@32=%b fd@99=%b required 0/100/1", g1, go_log[32], fd_log[99]);
    end
    do_reset();
    set_cfg(3'b000, 30, 32, 10, 12);
    run_frame(20, 0, 0);
    g1 = 0;
    for (int n = 1; n <= 20; n++) g1 += $countones(go_log[n]);
    checks++;
    if (g1 !== 0 || upd_log[1] !== 1'b1 || fd_log[14] !== 1'b0 || fd_log[15] !== 1'b1 || busy_log[16] !== 1'b0) begin
      failures++;
      $display("FAIL mask_none gos=%0d upd@1=%b fd@14=%b fd@15=%b busy@16=%b required 0/1/0/1/0",
               g1, upd_log[1], fd_log[14], fd_log[15], busy_log[16]);
    end
  endtask

  task automatic test_tick_queue();
    int novr;
    do_reset();
    set_cfg(3'b111, 30, 32, 10, 12);
    run_frame(170, 50, 100);
    novr = 0;
    for (int n = 1; n <= 170; n++) novr += int'(ovr_log[n]);
    checks++;
    if (novr !== 1 || ovr_log[100] !== 1'b1) begin
      failures++;
      $display("FAIL overrun count=%0d at100=%b required 1/1", novr, ovr_log[100]);
    end
    // Queued tick: one IDLE cycle after frame_done, then the next frame's LOAD.
    checks++;
    if (fd_log[165] !== 1'b1 || busy_log[166] !== 1'b0 || go_log[167] !== 3'b001 || pass_log[167] !== 1'b0) begin
      failures++;
      $display("FAIL queued_start fd@165=%b busy@166=%b go@167=%b pass@167=%b required 1/0/001/0",
               fd_log[165], busy_log[166], go_log[167], pass_log[167]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_cfg(3'b111, 30, 32, 10, 12);
    ch_we = 3'b111;
    ch_x = {10'd300, 10'd123, 10'd7};
    run_frame(45, 0, 0);
    checks++;
    if (we_log[45] !== 1'b1 || busy_log[45] !== 1'b1 || x_log[45] !== 10'd123) begin
      failures++;
      $display("FAIL pre_reset we=%b busy=%b x=%0d required 1/1/123", we_log[45], busy_log[45], x_log[45]);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (vga_we !== 1'b0 || busy !== 1'b0 || vga_x !== '0 || pass !== 1'b0 || go !== '0) begin
      failures++;
      $display("FAIL async_reset we=%b busy=%b x=%0d pass=%b go=%b required 0/0/0/0/000", vga_we, busy, vga_x, pass, go);
    end
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    run_frame(3, 0, 0);
    checks++;
    if (go_log[1] !== 3'b001 || pass_log[1] !== 1'b0) begin
      failures++;
      $display("FAIL restart go@1=%b pass@1=%b required 001/0", go_log[1], pass_log[1]);
    end
    ch_we = '0;
  endtask

  task automatic test_len_edge();
    do_reset();
    set_cfg(3'b111, 1, 1, 1, 0);
    run_frame(20, 0, 0);
    checks++;
    if (go_log[1] !== 3'b001 || go_log[3] !== 3'b010 || go_log[5] !== 3'b100 || go_log[9] !== 3'b001) begin
      failures++;
      $display("FAIL len1_go go@1=%b go@3=%b go@5=%b go@9=%b required 001/010/100/001", go_log[1], go_log[3], go_log[5], go_log[9]);
    end
    checks++;
    if (upd_log[7] !== 1'b1 || busy_log[8] !== 1'b1 || pass_log[9] !== 1'b1 || fd_log[15] !== 1'b1 || busy_log[16] !== 1'b0) begin
      failures++;
      $display("FAIL len1_upd upd@7=%b busy@8=%b pass@9=%b fd@15=%b busy@16=%b required 1/1/1/1/0",
               upd_log[7], busy_log[8], pass_log[9], fd_log[15], busy_log[16]);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pass_colour();
    test_masking();
    test_tick_queue();
    test_async_reset();
    test_len_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
